control_unit_seq: RTL and testbench

Multi-cycle, parametrised control unit for the pocket-calculator CPU. Sequences fetch/decode/execute/write-back for the 6-bit-opcode ISA (LDR, STR, branches, JMP/RET, ALU ops). Resolves branches from registered flags and keeps an internal return-address stack for JMP/RET. Sits between instruction memory, PC, register file/data memory muxes and the ALU/accumulator.

---
 rtl/control_unit_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_control_unit_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// Multi-cycle control unit for the pocket-calculator CPU: fetch/decode/execute/write-back
// sequencing, branch resolution from DECODE-sampled flags and a JMP/RET return stack.
module control_unit_seq #(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned OPC_W       = 6,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned IMM_W       = 9,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              Z,
    input  logic              N,
    input  logic              C,
    input  logic              O,
    output logic              instr_req,
    output logic [OPC_W-1:0]  opcode,
    output logic [IMM_W-1:0]  immediate,
    output logic              reg_addr,
    output logic              write_or_read,
    output logic              DW_or_DR,
    output logic              ACC_out,
    output logic [1:0]        W_R_C,
    output logic              alu_en,
    output logic              wb_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              psh,
    output logic              pop,
    output logic              halted,
    output logic              stack_err
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

    localparam logic [OPC_W-1:0] OP_LDR   = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_STR   = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_BRZ   = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_BRN   = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_BRC   = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_BRO   = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_BRA   = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] OP_RET   = OPC_W'(8'h08);
    localparam logic [OPC_W-1:0] OP_ALU_L = OPC_W'(8'h09);
    localparam logic [OPC_W-1:0] OP_ALU_H = OPC_W'(8'h1A);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pcl_q, pcl_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    logic                reg_addr_q, reg_addr_d;
    logic                wor_q, wor_d;
    logic                dwdr_q, dwdr_d;
    logic                acc_q, acc_d;
    logic [1:0]          wrc_q, wrc_d;
    logic                alu_en_q, alu_en_d;
    logic                wb_en_q, wb_en_d;
    logic                pc_load_q, pc_load_d;
    logic [ADDR_W-1:0]   pc_target_q, pc_target_d;
    logic                psh_q, psh_d;
    logic                pop_q, pop_d;
    logic                halted_q, halted_d;
    logic                stack_err_q, stack_err_d;
    logic                instr_req_q, instr_req_d;

    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

    logic [OPC_W-1:0]    dec_opc;
    logic [ADDR_W-1:0]   dec_tgt;
    logic [SP_W-1:0]     sp_m1;
    logic                stk_full, stk_empty, do_push;

    assign dec_opc   = instr_q[INSTR_W-1 -: OPC_W];
    assign dec_tgt   = instr_q[ADDR_W-1:0];
    assign sp_m1     = sp_q - SP_W'(1);
    assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);
    assign do_push   = (state_q == S_DECODE) && (dec_opc == OP_JMP) && !stk_full;

    // EXEC-cycle strobes are computed in DECODE and registered, so live flags
    // seen at the DECODE edge are the sampled branch condition.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pcl_d       = pcl_q;
        sp_d        = sp_q;
        opcode_d    = opcode_q;
        imm_d       = imm_q;
        reg_addr_d  = reg_addr_q;
        wor_d       = wor_q;
        dwdr_d      = dwdr_q;
        acc_d       = acc_q;
        wrc_d       = wrc_q;
        pc_target_d = pc_target_q;
        stack_err_d = stack_err_q;
        alu_en_d    = 1'b0;
        wb_en_d     = 1'b0;
        pc_load_d   = 1'b0;
        psh_d       = 1'b0;
        pop_d       = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr;
                    pcl_d   = pc;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d    = S_EXEC;
                opcode_d   = dec_opc;
                imm_d      = instr_q[IMM_W-1:0];
                reg_addr_d = instr_q[IMM_W];
                wor_d      = 1'b0;
                dwdr_d     = 1'b0;
                acc_d      = 1'b0;
                wrc_d      = 2'b00;
                case (dec_opc)
                    OP_LDR: begin
                        wor_d = 1'b1;
                        wrc_d = 2'b10;
                    end
                    OP_STR: dwdr_d = 1'b1;
                    OP_BRZ, OP_BRN, OP_BRC, OP_BRO, OP_BRA: begin
                        if ((dec_opc == OP_BRA) ||
                            (dec_opc == OP_BRZ && Z) || (dec_opc == OP_BRN && N) ||
                            (dec_opc == OP_BRC && C) || (dec_opc == OP_BRO && O)) begin
                            pc_load_d   = 1'b1;
                            pc_target_d = dec_tgt;
                        end
                    end
                    OP_JMP: begin
                        if (stk_full) begin
                            stack_err_d = 1'b1;
                        end else begin
                            psh_d       = 1'b1;
                            pc_load_d   = 1'b1;
                            pc_target_d = dec_tgt;
                            sp_d        = sp_q + SP_W'(1);
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            stack_err_d = 1'b1;
                        end else begin
                            pop_d       = 1'b1;
                            pc_load_d   = 1'b1;
                            pc_target_d = stack_mem[sp_m1[SP_W-2:0]];
                            sp_d        = sp_m1;
                        end
                    end
                    default: begin
                        if (dec_opc >= OP_ALU_L && dec_opc <= OP_ALU_H) begin
                            alu_en_d = 1'b1;
                            acc_d    = 1'b1;
                            wor_d    = 1'b1;
                            wrc_d    = 2'b01;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                if (opcode_q == OP_LDR || (opcode_q >= OP_ALU_L && opcode_q <= OP_ALU_H)) begin
                    state_d = S_WB;
                    wb_en_d = 1'b1;
                end else if (opcode_q <= OP_BRA) begin
                    state_d = S_FETCH;
                end else if (opcode_q == OP_JMP || opcode_q == OP_RET) begin
                    state_d = stack_err_q ? S_HALT : S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        instr_req_d = (state_d == S_FETCH);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            pcl_q       <= '0;
            sp_q        <= '0;
            opcode_q    <= '0;
            imm_q       <= '0;
            reg_addr_q  <= 1'b0;
            wor_q       <= 1'b0;
            dwdr_q      <= 1'b0;
            acc_q       <= 1'b0;
            wrc_q       <= 2'b00;
            alu_en_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            psh_q       <= 1'b0;
            pop_q       <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
            instr_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pcl_q       <= pcl_d;
            sp_q        <= sp_d;
            opcode_q    <= opcode_d;
            imm_q       <= imm_d;
            reg_addr_q  <= reg_addr_d;
            wor_q       <= wor_d;
            dwdr_q      <= dwdr_d;
            acc_q       <= acc_d;
            wrc_q       <= wrc_d;
            alu_en_q    <= alu_en_d;
            wb_en_q     <= wb_en_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            psh_q       <= psh_d;
            pop_q       <= pop_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
            instr_req_q <= instr_req_d;
        end
    end

    // Stack contents survive reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stack_mem[sp_q[SP_W-2:0]] <= pcl_q + ADDR_W'(1);
        end
    end

    assign instr_req     = instr_req_q;
    assign opcode        = opcode_q;
    assign immediate     = imm_q;
    assign reg_addr      = reg_addr_q;
    assign write_or_read = wor_q;
    assign DW_or_DR      = dwdr_q;
    assign ACC_out       = acc_q;
    assign W_R_C         = wrc_q;
    assign alu_en        = alu_en_q;
    assign wb_en         = wb_en_q;
    assign pc_load       = pc_load_q;
    assign pc_target     = pc_target_q;
    assign psh           = psh_q;
    assign pop           = pop_q;
    assign halted        = halted_q;
    assign stack_err     = stack_err_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed bench for control_unit_seq: ALU/LDR/STR flow, branches, JMP/RET stack,
// stack overflow/underflow, illegal opcode halt and reset during write-back.
module tb_control_unit_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        Z, N, C, O;
    logic        instr_req;
    logic [5:0]  opcode;
    logic [8:0]  immediate;
    logic        reg_addr;
    logic        write_or_read;
    logic        DW_or_DR;
    logic        ACC_out;
    logic [1:0]  W_R_C;
    logic        alu_en;
    logic        wb_en;
    logic        pc_load;
    logic [9:0]  pc_target;
    logic        psh;
    logic        pop;
    logic        halted;
    logic        stack_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    control_unit_seq #(
        .INSTR_W(16), .OPC_W(6), .ADDR_W(10), .IMM_W(9), .STACK_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .Z(Z), .N(N), .C(C), .O(O),
        .instr_req(instr_req), .opcode(opcode), .immediate(immediate), .reg_addr(reg_addr),
        .write_or_read(write_or_read), .DW_or_DR(DW_or_DR), .ACC_out(ACC_out), .W_R_C(W_R_C),
        .alu_en(alu_en), .wb_en(wb_en), .pc_load(pc_load), .pc_target(pc_target),
        .psh(psh), .pop(pop), .halted(halted), .stack_err(stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a fetch request, then presents one instruction for one edge.
    task automatic issue(input logic [15:0] iw, input logic [9:0] pcv);
        for (int i = 0; i < 20 && instr_req !== 1'b1; i++) tick();
        chk("instr_req_wait", {31'b0, instr_req}, 32'd1);
        instr = iw;
        pc = pcv;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; instr = '0; instr_valid = 1'b0; pc = '0;
        Z = 1'b0; N = 1'b0; C = 1'b0; O = 1'b0;
        tick();
        tick();
        chk("rst_instr_req", {31'b0, instr_req}, 0);
        chk("rst_opcode", {26'b0, opcode}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_stack_err", {31'b0, stack_err}, 0);
        chk("rst_pc_target", {22'b0, pc_target}, 0);
        reset = 1'b0;
        tick();
        chk("fetch_after_idle", {31'b0, instr_req}, 1);
        tick();
        tick();
        chk("instr_req_held", {31'b0, instr_req}, 1);

        // ALU op 0x09, imm 5
        issue(16'h2405, 10'h010);
        chk("alu_decode_no_req", {31'b0, instr_req}, 0);
        tick();
        chk("alu_en_exec", {31'b0, alu_en}, 1);
        chk("alu_wrc", {30'b0, W_R_C}, 1);
        chk("alu_acc_out", {31'b0, ACC_out}, 1);
        chk("alu_wor", {31'b0, write_or_read}, 1);
        chk("alu_opcode", {26'b0, opcode}, 32'h09);
        chk("alu_imm", {23'b0, immediate}, 5);
        chk("alu_wb_not_yet", {31'b0, wb_en}, 0);
        tick();
        chk("alu_wb_en", {31'b0, wb_en}, 1);
        chk("alu_en_one_cycle", {31'b0, alu_en}, 0);
        chk("alu_wb_no_req", {31'b0, instr_req}, 0);
        tick();
        chk("alu_wb_one_cycle", {31'b0, wb_en}, 0);
        chk("alu_req_back", {31'b0, instr_req}, 1);
        chk("alu_static_hold", {30'b0, W_R_C}, 1);

        // STR imm 0xAA
        issue(16'h04AA, 10'h011);
        tick();
        chk("str_wor", {31'b0, write_or_read}, 0);
        chk("str_dwdr", {31'b0, DW_or_DR}, 1);
        chk("str_wrc", {30'b0, W_R_C}, 0);
        chk("str_imm", {23'b0, immediate}, 32'hAA);
        tick();
        chk("str_req_back", {31'b0, instr_req}, 1);

        // BRZ taken, then flag change after DECODE
        Z = 1'b1;
        issue(16'h0812, 10'h020);
        tick();
        Z = 1'b0;
        chk("brz_taken_load", {31'b0, pc_load}, 1);
        chk("brz_taken_tgt", {22'b0, pc_target}, 32'h012);
        tick();
        chk("brz_load_one_cycle", {31'b0, pc_load}, 0);
        chk("brz_req_back", {31'b0, instr_req}, 1);

        // BRZ not taken; Z rises only during EXEC
        issue(16'h0812, 10'h021);
        tick();
        Z = 1'b1;
        chk("brz_not_taken", {31'b0, pc_load}, 0);
        tick();
        chk("brz_late_flag", {31'b0, pc_load}, 0);
        Z = 1'b0;

        // BRN taken, BRA unconditional
        N = 1'b1;
        issue(16'h0C33, 10'h022);
        tick();
        N = 1'b0;
        chk("brn_load", {31'b0, pc_load}, 1);
        chk("brn_tgt", {22'b0, pc_target}, 32'h033);
        issue(16'h1805, 10'h023);
        tick();
        chk("bra_load", {31'b0, pc_load}, 1);
        chk("bra_tgt", {22'b0, pc_target}, 32'h005);

        // JMP at pc=0x3FF wraps return address, then RET
        issue(16'h1C40, 10'h3FF);
        tick();
        chk("jmp_psh", {31'b0, psh}, 1);
        chk("jmp_load", {31'b0, pc_load}, 1);
        chk("jmp_tgt", {22'b0, pc_target}, 32'h040);
        issue(16'h2000, 10'h040);
        tick();
        chk("ret_pop", {31'b0, pop}, 1);
        chk("ret_load", {31'b0, pc_load}, 1);
        chk("ret_tgt_wrap", {22'b0, pc_target}, 32'h000);
        tick();
        chk("ret_pop_one_cycle", {31'b0, pop}, 0);

        // Fill 8 entries, LIFO check, refill, overflow
        for (int k = 0; k < 8; k++) begin
            issue(16'h1C40, 10'(32'h100 + k));
            tick();
            chk("fill_psh", {31'b0, psh}, 1);
        end
        issue(16'h2000, 10'h040);
        tick();
        chk("lifo_top", {22'b0, pc_target}, 32'h108);
        issue(16'h1C55, 10'h200);
        tick();
        chk("refill_psh", {31'b0, psh}, 1);
        issue(16'h1C66, 10'h201);
        tick();
        chk("ovf_stack_err", {31'b0, stack_err}, 1);
        chk("ovf_no_load", {31'b0, pc_load}, 0);
        chk("ovf_no_psh", {31'b0, psh}, 0);
        tick();
        chk("ovf_halted", {31'b0, halted}, 1);
        tick();
        tick();
        chk("ovf_no_req", {31'b0, instr_req}, 0);

        // Underflow after reset
        do_reset();
        chk("rst_clears_err", {31'b0, stack_err}, 0);
        chk("rst_clears_halt", {31'b0, halted}, 0);
        issue(16'h2000, 10'h050);
        tick();
        chk("unf_stack_err", {31'b0, stack_err}, 1);
        chk("unf_no_load", {31'b0, pc_load}, 0);
        chk("unf_no_pop", {31'b0, pop}, 0);
        tick();
        chk("unf_halted", {31'b0, halted}, 1);

        // Illegal opcode 0x3E
        do_reset();
        issue(16'hF800, 10'h060);
        tick();
        chk("ill_exec_not_halted", {31'b0, halted}, 0);
        tick();
        chk("ill_halted", {31'b0, halted}, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("ill_no_req", {31'b0, instr_req}, 0);
        chk("ill_still_halted", {31'b0, halted}, 1);

        // Reset during WB of LDR (reg_addr=1, imm=3)
        do_reset();
        issue(16'h0203, 10'h070);
        tick();
        chk("ldr_wor", {31'b0, write_or_read}, 1);
        chk("ldr_dwdr", {31'b0, DW_or_DR}, 0);
        chk("ldr_wrc", {30'b0, W_R_C}, 2);
        chk("ldr_reg_addr", {31'b0, reg_addr}, 1);
        tick();
        chk("ldr_wb_en", {31'b0, wb_en}, 1);
        reset = 1'b1;
        instr_valid = 1'b1;
        tick();
        reset = 1'b0;
        instr_valid = 1'b0;
        chk("rwb_wb_en", {31'b0, wb_en}, 0);
        chk("rwb_wrc", {30'b0, W_R_C}, 0);
        chk("rwb_wor", {31'b0, write_or_read}, 0);
        chk("rwb_req", {31'b0, instr_req}, 0);
        chk("rwb_reg_addr", {31'b0, reg_addr}, 0);
        tick();
        chk("rwb_fetch_resume", {31'b0, instr_req}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
